serdes_tx_gearbox: RTL and testbench
====================================

# serdes_tx_gearbox

Converts a stream of 10-bit line-coded (8b10b) symbols into 8-bit parallel words for an 8:1 output serializer running in the serializer's divided clock domain. Sits directly upstream of the 8:1 OSERDESE2 on the event transmit path: `out_data[0]` drives D1 and is the first bit on the wire. Every cycle it emits one word, 5 words per 4 symbols, and inserts an idle symbol when the source underruns so the line never stalls.

## Interface
- `IDLE_SYM`, 10'h17C, symbol inserted on underrun (K28.5 RD−, bit 0 = first transmitted bit "a").
- `UFLOW_W`, 16, width of the saturating underrun counter.

- `clk`  in  1  serializer divided clock (CLKDIV); sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  transmit enable.
- `s_data`  in  10  symbol; bit 0 transmitted first.
- `s_valid`  in  1  symbol available.
- `s_ready`  out  1  symbol accepted at this edge when `s_valid` is also high (combinational).
- `out_data`  out  8  word to serializer D1..D8 (bit 0 → D1); registered.
- `uflow_cnt`  out  UFLOW_W  count of inserted idle symbols, saturating at all-ones.
- `uflow`  out  1  one-cycle pulse, registered, when an idle symbol was inserted.

## Operation
- State: bit buffer `buf` (18 b) and fill count `cnt` ∈ {0,2,4,6,8}.
- Each active cycle (`en`=1, `rst`=0):
  - If `cnt` < 8, one symbol is appended at bit position `cnt`. The symbol is `s_data` when `s_valid`; otherwise it is `IDLE_SYM`, `uflow` pulses and `uflow_cnt` increments.
  - Then `out_data` ← low 8 bits of the merged buffer, the buffer shifts right by 8, and `cnt` ← `cnt`+2 (append) or 0 (`cnt` was 8).
- `s_ready` = `en` & ~`rst` & (`cnt` < 8). Symbols are never dropped; backpressure occurs only on the 5th cycle of each 5-cycle phase.
- `en` = 0: `s_ready` = 0, `cnt` ← 0, `buf` ← 0, `out_data` ← 0, no underrun counting. A partially sent symbol is discarded (deliberate; link-down case).
- Reset: `cnt` = 0, `buf` = 0, `out_data` = 0, `uflow` = 0, `uflow_cnt` = 0, `s_ready` = 0.
- Reset or `en` deassertion mid-phase gives the same result: the next active cycle restarts at `cnt` = 0 with no stale bits.
- Saturation: `uflow_cnt` holds at 2^UFLOW_W−1 and does not wrap. `uflow` still pulses.

## Timing
- Latency: a symbol accepted at edge N puts its bits [7−c:0] into `out_data` at edge N, visible in cycle N+1, where c is the `cnt` before the edge. Its remaining bits appear at edge N+1.
- Output cadence: one word per `clk`, unconditionally while `en` = 1.
- `s_ready` depends only on registered state plus `en`/`rst`; there is no combinational path from `s_valid` or `s_data`.
- First active edge after reset/enable: `cnt` = 0, so a symbol is always taken (or idle inserted).

## Structure
- Small shared constants file: `IDLE_SYM` default (K28.5 RD− = 10'h17C) and the symbol/word widths (10, 8), reused by the matching receive gearbox.
- No sub-module is required. The saturating counter may be a local `sat_counter` instance if one already exists; otherwise inline it.
- Target 120–200 lines of RTL.

## Test plan
- Reset: hold `rst` for 3 cycles with `s_valid` = 1 → `out_data` = 0, `s_ready` = 0, `uflow_cnt` = 0 throughout.
- Continuous stream 10'h17C, 10'h283, 10'h155, 10'h2AA from `cnt` = 0 → `out_data` sequence 8'h7C, 8'h0D, 8'h5A, 8'h95, 8'hAA. `s_ready` is low exactly on the 5th cycle.
- Underrun: `en` = 1, `s_valid` = 0 for 10 cycles → words 7C, F1, C5, 17, 5F repeating; `uflow` pulses 8 times; `uflow_cnt` = 8.
- Mixed: feed 10'h283 at `cnt` = 2 (after one idle) → word 2 = 8'h0D (idle bits 9:8 = 01, plus data bits 5:0 = 000011); remaining data bits follow in order. Continuity is verified by reassembling the bitstream in a scoreboard.
- Mid-phase abort: drop `en` (and separately pulse `rst`) at `cnt` = 4 → `out_data` = 0 next cycle. On re-enable the first word is the low 8 bits of the next accepted symbol; no stale bits appear.
- Saturation with `UFLOW_W` = 4: 20 underrun insertions → `uflow_cnt` stops at 15, `uflow` keeps pulsing.

Source files
------------

// File: rtl/serdes_tx_gearbox_pkg.sv
// rtl/serdes_tx_gearbox_pkg.sv - shared symbol/word constants for the serdes gearboxes
package serdes_tx_gearbox_pkg;

  localparam int SYM_W  = 10;
  localparam int WORD_W = 8;
  // Worst-case merged fill is 6 leftover bits plus one 10-bit symbol; two spare bits of headroom.
  localparam int BUF_W  = 18;
  localparam int CNT_W  = 4;

  localparam logic [SYM_W-1:0] IDLE_SYM_K28_5_RDN = 10'h17C;
  localparam logic [CNT_W-1:0] CNT_FULL           = 4'd8;
  localparam logic [CNT_W-1:0] CNT_STEP           = 4'd2;

endpackage

// File: rtl/serdes_tx_gearbox_sat_counter.sv
// rtl/serdes_tx_gearbox_sat_counter.sv - saturating event counter
module serdes_tx_gearbox_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment on request, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/serdes_tx_gearbox.sv
// rtl/serdes_tx_gearbox.sv - 10-bit symbol to 8-bit word transmit gearbox with idle fill
module serdes_tx_gearbox
  import serdes_tx_gearbox_pkg::*;
#(
  parameter logic [SYM_W-1:0] IDLE_SYM = IDLE_SYM_K28_5_RDN,
  parameter int               UFLOW_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [SYM_W-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [UFLOW_W-1:0] uflow_cnt,
  output logic               uflow
);

  logic [BUF_W-1:0]  buf_q;
  logic [BUF_W-1:0]  buf_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [WORD_W-1:0] out_data_q;
  logic [WORD_W-1:0] out_data_d;
  logic              uflow_q;
  logic              uflow_d;

  logic              room;
  logic              take;
  logic [SYM_W-1:0]  sym;
  logic [BUF_W-1:0]  appended;
  logic [BUF_W-1:0]  merged;

  // A symbol slot opens whenever fewer than a full word of bits is buffered; it depends
  // only on registered fill so s_ready never sees s_valid/s_data.
  assign room    = (cnt_q < CNT_FULL);
  assign take    = en & room;
  assign s_ready = en & ~rst & room;

  // Append the symbol (or idle on underrun) above the leftover bits, emit the low word,
  // keep the rest. Dropping en flushes everything, discarding any partial symbol.
  always_comb begin
    sym        = s_valid ? s_data : IDLE_SYM;
    appended   = take ? ({{(BUF_W-SYM_W){1'b0}}, sym} << cnt_q) : '0;
    merged     = buf_q | appended;
    buf_d      = '0;
    cnt_d      = '0;
    out_data_d = '0;
    uflow_d    = 1'b0;
    if (en) begin
      out_data_d = merged[WORD_W-1:0];
      buf_d      = merged >> WORD_W;
      cnt_d      = room ? (cnt_q + CNT_STEP) : '0;
      uflow_d    = take & ~s_valid;
    end
  end

  // Gearbox state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      uflow_q    <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      uflow_q    <= uflow_d;
    end
  end

  serdes_tx_gearbox_sat_counter #(
    .W (UFLOW_W)
  ) u_uflow_cnt (
    .clk (clk),
    .rst (rst),
    .inc (uflow_d),
    .cnt (uflow_cnt)
  );

  assign out_data = out_data_q;
  assign uflow    = uflow_q;

endmodule

// File: tb/tb_serdes_tx_gearbox.sv
// tb/tb_serdes_tx_gearbox.sv - bench for serdes_tx_gearbox against a bit-queue model
module tb_serdes_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [9:0]  s_data;
  logic        s_valid;

  logic        s_ready;
  logic [7:0]  out_data;
  logic [15:0] uflow_cnt;
  logic        uflow;

  logic        s_ready4;
  logic [7:0]  out_data4;
  logic [3:0]  uflow_cnt4;
  logic        uflow4;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: transmitted bits in wire order, plus expected registered outputs.
  logic       mq[$];
  logic [7:0] m_out   = '0;
  logic       m_uflow = 1'b0;
  int         m_ucnt  = 0;

  logic [7:0] last_word;
  logic       last_ready;
  int         pulses;

  always #5 clk = ~clk;

  serdes_tx_gearbox dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .out_data  (out_data),
    .uflow_cnt (uflow_cnt),
    .uflow     (uflow)
  );

  serdes_tx_gearbox #(.UFLOW_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready4),
    .out_data  (out_data4),
    .uflow_cnt (uflow_cnt4),
    .uflow     (uflow4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic r, input logic v, input logic [9:0] d);
    logic       exp_ready;
    logic [9:0] sym;
    en      = e;
    rst     = r;
    s_valid = v;
    s_data  = d;
    #1;
    exp_ready  = e && !r && (mq.size() < 8);
    last_ready = s_ready;
    check("s_ready", s_ready, exp_ready);
    check("s_ready_w4", s_ready4, exp_ready);
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_out   = '0;
      m_uflow = 1'b0;
      m_ucnt  = 0;
    end else if (!e) begin
      mq.delete();
      m_out   = '0;
      m_uflow = 1'b0;
    end else begin
      m_uflow = 1'b0;
      if (mq.size() < 8) begin
        sym = v ? d : 10'h17C;
        if (!v) begin
          m_uflow = 1'b1;
          m_ucnt++;
        end
        for (int i = 0; i < 10; i++) mq.push_back(sym[i]);
      end
      for (int i = 0; i < 8; i++) m_out[i] = mq.pop_front();
    end
    #1;
    check("out_data", out_data, m_out);
    check("out_data_w4", out_data4, m_out);
    check("uflow", uflow, m_uflow);
    check("uflow_w4", uflow4, m_uflow);
    check("uflow_cnt", uflow_cnt, (m_ucnt > 65535) ? 65535 : m_ucnt);
    check("uflow_cnt_w4", uflow_cnt4, (m_ucnt > 15) ? 15 : m_ucnt);
    last_word = out_data;
    if (uflow) pulses++;
  endtask

  initial begin
    logic [9:0] stream_syms[4];
    logic [7:0] stream_words[5];
    logic [7:0] idle_words[5];
    stream_syms  = '{10'h17C, 10'h283, 10'h155, 10'h2AA};
    stream_words = '{8'h7C, 8'h0D, 8'h5A, 8'h95, 8'hAA};
    idle_words   = '{8'h7C, 8'hF1, 8'hC5, 8'h17, 8'h5F};

    // Reset held with valid data offered.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 10'h3FF);
      check("rst_out", out_data, 8'h00);
      check("rst_ready", last_ready, 1'b0);
      check("rst_ucnt", uflow_cnt, 16'd0);
    end

    // Continuous stream from an empty buffer.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, (i < 4) ? stream_syms[i] : 10'h000);
      check("stream_word", last_word, stream_words[i]);
      check("stream_ready", last_ready, (i < 4) ? 1'b1 : 1'b0);
    end

    // Ten cycles of underrun after reset.
    step(1'b1, 1'b1, 1'b0, 10'h0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 10'h0);
      check("idle_word", last_word, idle_words[i % 5]);
    end
    check("idle_pulses", pulses, 8);
    check("idle_ucnt", uflow_cnt, 16'd8);

    // One idle then data at cnt = 2.
    step(1'b1, 1'b1, 1'b0, 10'h0);
    step(1'b1, 1'b0, 1'b0, 10'h0);
    check("mixed_w1", last_word, 8'h7C);
    step(1'b1, 1'b0, 1'b1, 10'h283);
    check("mixed_w2", last_word, 8'h0D);
    step(1'b1, 1'b0, 1'b1, 10'h0F0);
    step(1'b1, 1'b0, 1'b1, 10'h30F);
    step(1'b1, 1'b0, 1'b0, 10'h0);

    // Abort by en at cnt = 4, then re-enable.
    step(1'b1, 1'b1, 1'b0, 10'h0);
    step(1'b1, 1'b0, 1'b1, 10'h2AB);
    step(1'b1, 1'b0, 1'b1, 10'h1CD);
    step(1'b0, 1'b0, 1'b1, 10'h3EF);
    check("abort_en_out", last_word, 8'h00);
    check("abort_en_rdy", last_ready, 1'b0);
    step(1'b1, 1'b0, 1'b1, 10'h2F1);
    check("abort_en_first", last_word, 8'hF1);
    step(1'b1, 1'b0, 1'b1, 10'h004);

    // Abort by rst at cnt = 4, then resume.
    step(1'b1, 1'b1, 1'b0, 10'h0);
    step(1'b1, 1'b0, 1'b1, 10'h2AB);
    step(1'b1, 1'b0, 1'b1, 10'h1CD);
    step(1'b1, 1'b1, 1'b1, 10'h3EF);
    check("abort_rst_out", last_word, 8'h00);
    step(1'b1, 1'b0, 1'b1, 10'h2F1);
    check("abort_rst_first", last_word, 8'hF1);
    step(1'b1, 1'b0, 1'b1, 10'h004);

    // Saturation: 25 underrun cycles insert 20 idles.
    step(1'b1, 1'b1, 1'b0, 10'h0);
    pulses = 0;
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b0, 10'h0);
    check("sat_pulses", pulses, 20);
    check("sat_ucnt4", uflow_cnt4, 4'd15);
    check("sat_ucnt16", uflow_cnt, 16'd20);

    // Randomized traffic with occasional enable drops and resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7), 10'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
